// File: rtl/switch_input.sv
// rtl/switch_input.sv - debounced board switches and single-step button
//
// Purpose:
//   Synchronizes the 16 board switches and the single-step button, then
//   debounces every bit on a slow sample tick. A bit's new level is accepted
//   only after STABLE_CNT consecutive sample ticks in which the synchronized
//   value differs from the held level. Any agreeing tick restarts the count.
//   The debounced button produces a single-cycle press pulse. Any debounced
//   switch change produces a single-cycle change pulse.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   sw_raw     in   [15] run, [14:3] address, [2:0] display mode (raw)
//   btn_raw    in   single-step button (raw, high when pressed)
//   run_sw     out  debounced sw_raw[15]
//   in_addr    out  debounced sw_raw[14:3]
//   mode_sel   out  debounced sw_raw[2:0]
//   mode_valid out  mode_sel in 3'b001..3'b101
//   step_pulse out  one cycle per accepted button press
//   sw_changed out  one cycle per debounced switch update

module switch_input #(
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_CNT = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sw_raw,
    input  logic        btn_raw,
    output logic        run_sw,
    output logic [11:0] in_addr,
    output logic [2:0]  mode_sel,
    output logic        mode_valid,
    output logic        step_pulse,
    output logic        sw_changed
);

    localparam int NBITS = 17;
    localparam int BTN   = 16;
    localparam int CW    = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;

    localparam logic [CW-1:0] TICK_LAST  = CW'(SAMPLE_DIV - 1);
    localparam logic [3:0]    STAB_LAST  = 4'(STABLE_CNT - 1);

    // Bit 16 carries the button so all 17 inputs share one datapath.
    logic [NBITS-1:0] sync1;
    logic [NBITS-1:0] sync2;
    logic [NBITS-1:0] deb;
    logic [3:0]       stab [NBITS];

    logic [CW-1:0]    tick_cnt;
    logic             sample_tick;

    // Delayed copies of the debounced levels for edge detection.
    logic             btn_prev;
    logic [15:0]      sw_prev;

    assign sample_tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            deb      <= '0;
            tick_cnt <= '0;
            for (int i = 0; i < NBITS; i++) begin
                stab[i] <= 4'd0;
            end
        end else begin
            sync1 <= {btn_raw, sw_raw};
            sync2 <= sync1;

            if (sample_tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end

            // Debounced levels and counters only move on sample ticks; raw
            // activity between ticks has no effect at all.
            if (sample_tick) begin
                for (int i = 0; i < NBITS; i++) begin
                    if (sync2[i] == deb[i]) begin
                        stab[i] <= 4'd0;
                    end else if (stab[i] == STAB_LAST) begin
                        deb[i]  <= sync2[i];
                        stab[i] <= 4'd0;
                    end else begin
                        stab[i] <= stab[i] + 4'd1;
                    end
                end
            end
        end
    end

    // Pulse stage. The previous-level registers are cleared together with
    // the debounced levels, so reset never leaves an edge behind and any
    // pulse that would have fired on a reset edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_prev   <= 1'b0;
            sw_prev    <= '0;
            step_pulse <= 1'b0;
            sw_changed <= 1'b0;
        end else begin
            btn_prev   <= deb[BTN];
            sw_prev    <= deb[15:0];
            step_pulse <= deb[BTN] & ~btn_prev;
            sw_changed <= |(deb[15:0] ^ sw_prev);
        end
    end

    assign run_sw   = deb[15];
    assign in_addr  = deb[14:3];
    assign mode_sel = deb[2:0];

    always_comb begin
        mode_valid = 1'b0;
        case (mode_sel)
            3'b001, 3'b010, 3'b011, 3'b100, 3'b101: mode_valid = 1'b1;
            default:                                mode_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_switch_input.sv
// tb/tb_switch_input.sv - self-checking bench for switch_input

module tb_switch_input;

    logic        clk;
    logic        reset;
    logic [15:0] sw_raw;
    logic        btn_raw;
    logic        run_sw;
    logic [11:0] in_addr;
    logic [2:0]  mode_sel;
    logic        mode_valid;
    logic        step_pulse;
    logic        sw_changed;

    switch_input #(
        .SAMPLE_DIV(4),
        .STABLE_CNT(3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw_raw    (sw_raw),
        .btn_raw   (btn_raw),
        .run_sw    (run_sw),
        .in_addr   (in_addr),
        .mode_sel  (mode_sel),
        .mode_valid(mode_valid),
        .step_pulse(step_pulse),
        .sw_changed(sw_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Free-running pulse counters, sampled on the falling edge.
    int n_swch = 0;
    int n_step = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (sw_changed === 1'b1) n_swch++;
        if (step_pulse === 1'b1) n_step++;
        if (sw_changed === 1'b1 && step_pulse === 1'b1) n_both++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] sw;
        logic        btn;
        logic        run;
        logic [11:0] addr;
        logic [2:0]  mode;
        logic        valid;
        int          n_sw;
        int          n_step;
    } vec_t;

    vec_t vecs [12];

    int b_sw;
    int b_step;
    int b_both;

    initial begin
        vecs[0]  = '{16'h0019, 1'b0, 1'b0, 12'h003, 3'd1, 1'b1, 1, 0};
        vecs[1]  = '{16'h8002, 1'b0, 1'b1, 12'h000, 3'd2, 1'b1, 1, 0};
        vecs[2]  = '{16'h7FFB, 1'b0, 1'b0, 12'hFFF, 3'd3, 1'b1, 1, 0};
        vecs[3]  = '{16'h0AB4, 1'b0, 1'b0, 12'h156, 3'd4, 1'b1, 1, 0};
        vecs[4]  = '{16'h0AB5, 1'b0, 1'b0, 12'h156, 3'd5, 1'b1, 1, 0};
        vecs[5]  = '{16'h0AB6, 1'b0, 1'b0, 12'h156, 3'd6, 1'b0, 1, 0};
        vecs[6]  = '{16'h0AB7, 1'b0, 1'b0, 12'h156, 3'd7, 1'b0, 1, 0};
        vecs[7]  = '{16'h0AB0, 1'b0, 1'b0, 12'h156, 3'd0, 1'b0, 1, 0};
        vecs[8]  = '{16'h0AB0, 1'b1, 1'b0, 12'h156, 3'd0, 1'b0, 0, 1};
        vecs[9]  = '{16'h0AB0, 1'b1, 1'b0, 12'h156, 3'd0, 1'b0, 0, 0};
        vecs[10] = '{16'h0AB0, 1'b0, 1'b0, 12'h156, 3'd0, 1'b0, 0, 0};
        vecs[11] = '{16'hFFFD, 1'b0, 1'b1, 12'hFFF, 3'd5, 1'b1, 1, 0};

        reset   = 1'b1;
        sw_raw  = 16'h0000;
        btn_raw = 1'b0;
        tick(3);
        check("init_run",   32'(run_sw),     32'd0);
        check("init_addr",  32'(in_addr),    32'd0);
        check("init_mode",  32'(mode_sel),   32'd0);
        check("init_valid", 32'(mode_valid), 32'd0);
        check("init_step",  32'(step_pulse), 32'd0);
        check("init_swch",  32'(sw_changed), 32'd0);
        reset = 1'b0;

        // Table-driven clean changes; 24 cycles covers the worst-case
        // 2 + 3*4 latency plus the pulse cycle.
        for (int i = 0; i < 12; i++) begin
            b_sw    = n_swch;
            b_step  = n_step;
            sw_raw  = vecs[i].sw;
            btn_raw = vecs[i].btn;
            tick(24);
            check($sformatf("v%0d_run", i),   32'(run_sw),     32'(vecs[i].run));
            check($sformatf("v%0d_addr", i),  32'(in_addr),    32'(vecs[i].addr));
            check($sformatf("v%0d_mode", i),  32'(mode_sel),   32'(vecs[i].mode));
            check($sformatf("v%0d_valid", i), 32'(mode_valid), 32'(vecs[i].valid));
            check($sformatf("v%0d_nswch", i), 32'(n_swch - b_sw),   32'(vecs[i].n_sw));
            check($sformatf("v%0d_nstep", i), 32'(n_step - b_step), 32'(vecs[i].n_step));
        end

        // Bouncing button: 5-cycle high phases never span 3 ticks.
        b_step = n_step;
        for (int i = 0; i < 8; i++) begin
            btn_raw = (i % 2 == 0);
            tick(5);
        end
        check("bounce_nstep", 32'(n_step - b_step), 32'd0);
        b_step  = n_step;
        b_sw    = n_swch;
        btn_raw = 1'b1;
        tick(40);
        check("hold_nstep", 32'(n_step - b_step), 32'd1);
        check("hold_nswch", 32'(n_swch - b_sw),   32'd0);
        b_step  = n_step;
        btn_raw = 1'b0;
        tick(40);
        check("release_nstep", 32'(n_step - b_step), 32'd0);

        // Simultaneous switch and button change.
        b_sw    = n_swch;
        b_step  = n_step;
        b_both  = n_both;
        sw_raw  = 16'hFFFE;
        btn_raw = 1'b1;
        tick(24);
        check("simul_nswch", 32'(n_swch - b_sw),   32'd1);
        check("simul_nstep", 32'(n_step - b_step), 32'd1);
        check("simul_nboth", 32'(n_both - b_both), 32'd1);
        check("simul_mode",  32'(mode_sel),        32'd6);
        check("simul_valid", 32'(mode_valid),      32'd0);

        // Reset with all switches high, then qualification after release.
        reset   = 1'b1;
        sw_raw  = 16'hFFFF;
        btn_raw = 1'b0;
        tick(3);
        check("rst_run",   32'(run_sw),     32'd0);
        check("rst_addr",  32'(in_addr),    32'd0);
        check("rst_mode",  32'(mode_sel),   32'd0);
        check("rst_valid", 32'(mode_valid), 32'd0);
        check("rst_step",  32'(step_pulse), 32'd0);
        check("rst_swch",  32'(sw_changed), 32'd0);
        b_sw   = n_swch;
        b_step = n_step;
        reset  = 1'b0;
        tick(14);
        check("post_run",   32'(run_sw),     32'd1);
        check("post_addr",  32'(in_addr),    32'hFFF);
        check("post_mode",  32'(mode_sel),   32'd7);
        check("post_valid", 32'(mode_valid), 32'd0);
        tick(10);
        check("post_nswch", 32'(n_swch - b_sw),   32'd1);
        check("post_nstep", 32'(n_step - b_step), 32'd0);

        // Reset aborts a qualification two ticks in; ticks land on the
        // 4th, 8th, 12th edges after release.
        reset  = 1'b1;
        sw_raw = 16'h0000;
        tick(2);
        reset  = 1'b0;
        sw_raw = 16'h8000;
        tick(8);
        reset  = 1'b1;
        tick(1);
        check("abort_rst_run", 32'(run_sw), 32'd0);
        reset  = 1'b0;
        tick(3);
        check("abort_early_run", 32'(run_sw), 32'd0);
        tick(8);
        check("abort_late_run", 32'(run_sw), 32'd0);
        tick(1);
        check("abort_done_run", 32'(run_sw), 32'd1);

        // Reset on the edge that would register a step pulse.
        reset   = 1'b1;
        sw_raw  = 16'h0000;
        tick(2);
        reset   = 1'b0;
        btn_raw = 1'b1;
        tick(12);
        check("supp_before", 32'(step_pulse), 32'd0);
        reset   = 1'b1;
        tick(1);
        check("supp_step", 32'(step_pulse), 32'd0);
        b_step  = n_step;
        reset   = 1'b0;
        tick(16);
        check("supp_requal_nstep", 32'(n_step - b_step), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/switch_input.md
SWITCH_INPUT -- requirements
Module: switch_input

Interface
REQ-001 SHALL have parameter SAMPLE_DIV, default 100000, clock cycles per debounce sample tick (1 ms at 100 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter STABLE_CNT, default 10, consecutive differing sample ticks required to accept a new level; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sw_raw, input, 16, raw board switches, asynchronous and bouncing: [15] run switch, [14:3] address, [2:0] display mode.
REQ-006 SHALL have port btn_raw, input, 1, raw single-step push button, asynchronous and bouncing, high when pressed.
REQ-007 SHALL have port run_sw, output, 1, debounced sw_raw[15].
REQ-008 SHALL have port in_addr, output, 12, debounced sw_raw[14:3].
REQ-009 SHALL have port mode_sel, output, 3, debounced sw_raw[2:0].
REQ-010 SHALL have port mode_valid, output, 1, high when mode_sel is in 3'b001..3'b101.
REQ-011 SHALL have port step_pulse, output, 1, one-cycle pulse per accepted button press.
REQ-012 SHALL have port sw_changed, output, 1, one-cycle pulse when any debounced switch bit changes.

Function
REQ-013 SHALL pass each of the 17 raw inputs through a 2-flop synchronizer before any other use.
REQ-014 SHALL run a free tick counter 0..SAMPLE_DIV-1, wrapping to 0; sample_tick is high in the cycle where the count equals SAMPLE_DIV-1.
REQ-015 SHALL keep, per bit, a debounced level and a 4-bit stability counter, updated only in sample_tick cycles.
REQ-016 In a tick where the synchronized bit equals its debounced level, SHALL clear that bit's counter.
REQ-017 In a tick where they differ and the counter is below STABLE_CNT-1, SHALL increment the counter.
REQ-018 In a tick where they differ and the counter equals STABLE_CNT-1, SHALL load the synchronized value into the debounced level and clear the counter. A change is therefore accepted on the STABLE_CNT-th consecutive differing tick.
REQ-019 Any bounce, meaning a tick with equal levels, SHALL restart qualification from zero; no partial credit is kept.
REQ-020 Between ticks, counters and debounced levels SHALL hold, regardless of raw input activity.
REQ-021 run_sw, in_addr and mode_sel SHALL be direct registered copies of the debounced levels. There is no added latency beyond the debounced register.
REQ-022 mode_valid SHALL be combinational from mode_sel: high for 001, 010, 011, 100 and 101; low for 000, 110 and 111.
REQ-023 step_pulse SHALL be high for exactly one cycle, the cycle after the debounced button level goes 0->1; a debounced release (1->0) SHALL produce no pulse.
REQ-024 Holding the button SHALL produce exactly one step_pulse; there is no auto-repeat.
REQ-025 sw_changed SHALL be high for exactly one cycle, the cycle after any of the 16 debounced switch bits updates. Several bits updating in the same tick SHALL yield a single pulse.
REQ-026 A button update alone SHALL NOT assert sw_changed, and a switch update alone SHALL NOT assert step_pulse. Simultaneous button and switch updates SHALL assert both pulses in the same cycle.
REQ-027 Total latency from a clean raw edge to the debounced output change SHALL be between 2+(STABLE_CNT-1)*SAMPLE_DIV+1 and 2+STABLE_CNT*SAMPLE_DIV cycles.

Reset
REQ-028 While reset is high at a clock edge, SHALL clear the synchronizers, the tick counter, all stability counters and all debounced levels.
REQ-029 While reset is high, all outputs SHALL be 0, and mode_valid SHALL be 0.
REQ-030 Reset SHALL override a qualification in progress; after release, qualification restarts from zero.
REQ-031 Inputs already high at reset release SHALL appear only after full qualification, accompanied by the normal sw_changed or step_pulse.
REQ-032 Reset asserted in the same cycle as a pending pulse SHALL suppress that pulse.

Verification (SAMPLE_DIV=4, STABLE_CNT=3)
REQ-033 Scenario: hold reset 3 cycles with sw_raw=16'hFFFF -> all outputs 0 during reset; after release, run_sw=1, in_addr=12'hFFF, mode_sel=3'b111 and mode_valid=0 within 2+12 cycles, with exactly one sw_changed pulse.
REQ-034 Scenario: from sw_raw=0, set sw_raw=16'h0019 (mode 001, addr 3) cleanly -> mode_sel=1, in_addr=3, mode_valid=1 after 3 ticks; one sw_changed pulse; step_pulse stays 0.
REQ-035 Scenario: toggle btn_raw high/low every 5 cycles for 40 cycles, then hold high 40 cycles -> no step_pulse during the toggling; exactly one step_pulse after the hold; a 40-cycle release then produces no pulse.
REQ-036 Scenario: change sw_raw[2:0] to 3'b110 and btn_raw to 1 in the same cycle -> sw_changed and step_pulse both high in the same single cycle; mode_valid=0.
REQ-037 Scenario: begin a sw_raw[15] 0->1 change, assert reset for 1 cycle after 2 ticks of qualification -> run_sw stays 0 until 3 further full ticks after reset release.
